icache_ctrl: RTL and testbench
==============================

# icache_ctrl

Direct-mapped instruction cache with a miss-refill state machine. Sits between the PC/IF stage and main memory. Serves hits combinationally in the fetch cycle. On a miss, it raises `ic_stall` toward the pipeline flow controller and refills one line from memory through a request/acknowledge handshake.

## Interface
- `ADDR_W`, 32, byte-address width of `addr` and `mem_addr`.
- `NUM_LINES`, 4, number of cache lines; power of two, at least 2.
- `WORDS_PER_LINE`, 4, 32-bit words per line; power of two, at least 2.
- `clk` input 1: rising-edge clock.
- `reset` input 1: reset, synchronous, active-high.
- `rd_en` input 1: fetch request valid this cycle.
- `addr` input `ADDR_W`: fetch byte address (the PC).
- `instr` output 32: fetched instruction.
- `ic_stall` output 1: fetch not satisfied this cycle.
- `mem_req` output 1: line refill request.
- `mem_addr` output `ADDR_W`: line-aligned refill address.
- `mem_ack` input 1: refill data valid this cycle.
- `mem_rdata` input `32*WORDS_PER_LINE`: refill line; word 0 is in the LSBs.

## Operation
Address split, with OFF = log2(`WORDS_PER_LINE`) and IDX = log2(`NUM_LINES`):
- `addr[1:0]`: ignored.
- Word offset: `addr[OFF+1:2]`.
- Index: `addr[OFF+IDX+1:OFF+2]`.
- Tag: the remaining upper bits.

Storage is one valid bit, one tag and one data line per index. Only the valid bits are reset. Tag and data arrays are not reset.

The state machine has two states, IDLE and FILL.

IDLE:
- hit = `rd_en` & valid[idx] & (tag[idx] == addr tag).
- On a hit: `instr` is the selected word and `ic_stall` is 0.
- On a miss with `rd_en` high: `ic_stall` is 1 and `instr` is 32'h0 (NOP). At the clock edge, latch `mem_addr` = `addr` with its low OFF+2 bits zeroed, then go to FILL.
- With `rd_en` low: `ic_stall` is 0, `instr` is 32'h0, and the state does not change.

FILL:
- `ic_stall` is 1, `instr` is 32'h0, and `mem_req` = 1.
- `mem_addr` holds its latched value.
- `addr` is ignored. A branch redirecting the PC does not abort the refill.
- On an edge where `mem_ack` is 1:
  - write `mem_rdata` into the data array at the latched index;
  - write the latched tag;
  - set the valid bit;
  - go to IDLE.

Boundary conditions:
- The IDLE lookup after a fill always re-evaluates the current `addr`. If the PC changed during the fill, that lookup can miss and start a new fill.
- `mem_ack` is ignored in IDLE. This covers stale acks after a reset.
- A conflict miss overwrites the resident line unconditionally.
- `mem_req` is decoded from the state and is never asserted in IDLE.

Reset:
- Outputs: state IDLE, `mem_req` 0, `mem_addr` 0, `ic_stall` 0, `instr` 0.
- All valid bits are cleared.
- Reset has priority over everything. A reset during FILL abandons the refill, and no array write happens.

## Timing
- Hit: zero latency. `instr` is valid in the same cycle as `addr`.
- Miss detected at cycle t:
  - `ic_stall` is 1 in t.
  - `mem_req` is 1 from t+1 until `mem_ack` is sampled at t+k, where k ≥ 1.
  - The line is written at the end of t+k.
  - At t+k+1 the state is IDLE and `mem_req` is 0. `ic_stall` is 0 if `addr` is unchanged.
- Minimum miss penalty is 2 stall cycles, when `mem_ack` is already high in the first FILL cycle.
- Memory may hold `mem_ack` high across cycles. Only the first ack in FILL is consumed; later acks land in IDLE and are ignored.

## Structure
- Shared package/header `icache_pkg`:
  - state encodings: IDLE = 1'b0, FILL = 1'b1;
  - localparams for OFF, IDX, TAG_W and LINE_W;
  - field-extract functions for offset, index and tag.
- Sub-module `icache_array`:
  - holds the valid, tag and data storage;
  - one combinational read port and one synchronous write port;
  - synchronous clear of the valid bits on reset.
- `icache_ctrl` contains the FSM, the hit compare and the word multiplexer.

## Test plan
All scenarios use the defaults: index is `addr[5:4]` and tag is `addr[31:6]`.
- **Cold miss:** after reset, `rd_en`=1 and `addr`=0x40. Required response:
  - `ic_stall` is 1 at once;
  - next cycle `mem_req`=1 and `mem_addr`=0x40;
  - ack 3 cycles later with line {0x4,0x3,0x2,0x1};
  - the following cycle `ic_stall`=0 and `instr`=0x1.
- **Hit:** after the cold miss, `addr`=0x48, then 0x4C. `instr` is 0x3, then 0x4, with `ic_stall` 0 and no `mem_req`.
- **Conflict miss:** `addr`=0x00 evicts line 0x40 (same index 0, tag 0). Then `addr`=0x40 misses again and `mem_addr`=0x40.
- **PC change during FILL:** fill for 0x40 in progress while `addr` switches to 0x10. The fill completes for 0x40, and the next IDLE cycle misses with `mem_addr`=0x10.
- **Reset during FILL:** assert `reset` 2 cycles into FILL. Required response:
  - `mem_req` is 0 the next cycle;
  - a late `mem_ack` is ignored;
  - a lookup of 0x40 misses.
- **Held ack:** `mem_ack` held high for 3 cycles during a single fill. Exactly one array write occurs, and IDLE does not issue a new `mem_req` unless `addr` misses.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg
// Shared definitions for the direct-mapped instruction cache:
//   - cache geometry (address width, line count, words per line) and the
//     field widths derived from it;
//   - FSM state encoding;
//   - address field extract helpers (word offset, line index, tag,
//     line-aligned address).
// The geometry is set here once so that the interface, the storage array
// and the controller always agree on the address split.
package icache_pkg;

  localparam int ADDR_W         = 32;
  localparam int NUM_LINES      = 4;
  localparam int WORDS_PER_LINE = 4;

  localparam int OFF    = $clog2(WORDS_PER_LINE);
  localparam int IDX    = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_W - OFF - IDX - 2;
  localparam int LINE_W = 32 * WORDS_PER_LINE;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  // Word offset inside the line; the byte offset addr[1:0] is dropped.
  function automatic logic [OFF-1:0] f_offset(input logic [ADDR_W-1:0] a);
    return a[OFF+1:2];
  endfunction

  function automatic logic [IDX-1:0] f_index(input logic [ADDR_W-1:0] a);
    return a[OFF+IDX+1:OFF+2];
  endfunction

  function automatic logic [TAG_W-1:0] f_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:OFF+IDX+2];
  endfunction

  // Address of the first byte of the line containing a.
  function automatic logic [ADDR_W-1:0] f_line_addr(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFF+2], {(OFF+2){1'b0}}};
  endfunction

endpackage

// File: rtl/icache_if.sv
// icache_if
// Bundles the fetch-side and memory-side signals of the instruction cache.
//   rd_en     : fetch request valid this cycle        (pipeline -> cache)
//   addr      : fetch byte address (PC)               (pipeline -> cache)
//   instr     : fetched instruction                   (cache -> pipeline)
//   ic_stall  : fetch not satisfied this cycle        (cache -> pipeline)
//   mem_req   : line refill request                   (cache -> memory)
//   mem_addr  : line-aligned refill address           (cache -> memory)
//   mem_ack   : refill data valid this cycle          (memory -> cache)
//   mem_rdata : refill line, word 0 in the LSBs       (memory -> cache)
// Modport slave is the cache's view; master is the environment's view.
interface icache_if;
  import icache_pkg::*;

  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       instr;
  logic              ic_stall;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_rdata;

  modport slave (
    input  rd_en, addr, mem_ack, mem_rdata,
    output instr, ic_stall, mem_req, mem_addr
  );

  modport master (
    output rd_en, addr, mem_ack, mem_rdata,
    input  instr, ic_stall, mem_req, mem_addr
  );

endinterface

// File: rtl/icache_array.sv
// icache_array
// Valid / tag / data storage for the direct-mapped cache.
//   i_clk, i_reset : clock and synchronous active-high reset
//   i_rd_idx       : combinational read index
//   o_rd_valid     : valid bit at i_rd_idx
//   o_rd_tag       : stored tag at i_rd_idx
//   o_rd_line      : stored data line at i_rd_idx
//   i_we           : write strobe (line, tag, and set valid)
//   i_wr_idx       : write index
//   i_wr_tag       : tag to store
//   i_wr_line      : data line to store
// Only the valid bits are reset; tag and data come up undefined and are
// never used before their valid bit is set. Reset beats a same-cycle write.
module icache_array
  import icache_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [IDX-1:0]    i_rd_idx,
  output logic              o_rd_valid,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic [LINE_W-1:0] o_rd_line,
  input  logic              i_we,
  input  logic [IDX-1:0]    i_wr_idx,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [LINE_W-1:0] i_wr_line
);

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_W-1:0]    r_data [NUM_LINES];

  // Valid bits: cleared on reset, set by a refill write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag and data storage: not reset, written only by a refill.
  always_ff @(posedge i_clk) begin
    if (!i_reset && i_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_line;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_line  = r_data[i_rd_idx];

endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl
// Direct-mapped instruction cache controller with a two-state refill FSM.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; abandons any refill in progress
//   bus   : icache_if.slave
//           rd_en/addr in, instr/ic_stall out (fetch side),
//           mem_req/mem_addr out, mem_ack/mem_rdata in (refill side)
// Hits are served combinationally in the fetch cycle. A miss stalls the
// fetch, latches the line address, and waits in FILL for the first mem_ack,
// which writes the line. The PC is not looked at during FILL, so a redirect
// never aborts a refill; the IDLE lookup afterwards re-evaluates addr.
module icache_ctrl
  import icache_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  icache_if.slave  bus
);

  state_e            r_state;
  state_e            w_next_state;
  logic [ADDR_W-1:0] r_mem_addr;

  logic [OFF-1:0]    w_rd_off;
  logic [IDX-1:0]    w_rd_idx;
  logic [TAG_W-1:0]  w_rd_tag;
  logic              w_valid;
  logic [TAG_W-1:0]  w_tag;
  logic [LINE_W-1:0] w_line;
  logic              w_hit;
  logic              w_miss;
  logic [31:0]       w_word;
  logic              w_we;

  logic [31:0]       w_instr;
  logic              w_ic_stall;
  logic              w_mem_req;

  assign w_rd_off = f_offset(bus.addr);
  assign w_rd_idx = f_index(bus.addr);
  assign w_rd_tag = f_tag(bus.addr);

  assign w_hit  = bus.rd_en & w_valid & (w_tag == w_rd_tag);
  assign w_miss = bus.rd_en & ~w_hit;
  assign w_word = w_line[{w_rd_off, 5'd0} +: 32];

  // Only the first ack seen in FILL writes; reset suppresses it.
  assign w_we = (r_state == ST_FILL) & bus.mem_ack & ~reset;

  icache_array u_array (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_rd_idx   (w_rd_idx),
    .o_rd_valid (w_valid),
    .o_rd_tag   (w_tag),
    .o_rd_line  (w_line),
    .i_we       (w_we),
    .i_wr_idx   (f_index(r_mem_addr)),
    .i_wr_tag   (f_tag(r_mem_addr)),
    .i_wr_line  (bus.mem_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_miss) begin
          w_next_state = ST_FILL;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (bus.mem_ack) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_FILL;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Refill address: captured on the IDLE miss edge, held through FILL.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_addr <= '0;
    end else if ((r_state == ST_IDLE) && w_miss) begin
      r_mem_addr <= f_line_addr(bus.addr);
    end
  end

  // Output decode; everything is forced quiet while reset is asserted.
  always_comb begin
    w_instr    = 32'h0;
    w_ic_stall = 1'b0;
    w_mem_req  = 1'b0;
    if (reset) begin
      w_instr    = 32'h0;
      w_ic_stall = 1'b0;
      w_mem_req  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            w_instr    = w_word;
            w_ic_stall = 1'b0;
          end else begin
            // rd_en low gives no stall; a real miss stalls with a NOP.
            w_instr    = 32'h0;
            w_ic_stall = bus.rd_en;
          end
        end
        ST_FILL: begin
          w_instr    = 32'h0;
          w_ic_stall = 1'b1;
          w_mem_req  = 1'b1;
        end
        default: begin
          w_instr    = 32'h0;
          w_ic_stall = 1'b0;
          w_mem_req  = 1'b0;
        end
      endcase
    end
  end

  assign bus.instr    = w_instr;
  assign bus.ic_stall = w_ic_stall;
  assign bus.mem_req  = w_mem_req;
  assign bus.mem_addr = r_mem_addr;

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl
// Directed bench for icache_ctrl with hand-computed expectations.
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled 1 unit later, well away from the active edge.
module tb_icache_ctrl;
  import icache_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  icache_if bus ();

  icache_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    reset          = 1'b1;
    bus.rd_en      = 1'b0;
    bus.addr       = 32'h0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;

    // Reset state, with a fetch presented during reset.
    step();
    step();
    bus.rd_en = 1'b1;
    bus.addr  = 32'h40;
    settle();
    check_eq("rst_stall",   {31'd0, bus.ic_stall}, 32'd0);
    check_eq("rst_instr",   bus.instr,             32'h0);
    check_eq("rst_req",     {31'd0, bus.mem_req},  32'd0);
    check_eq("rst_memaddr", bus.mem_addr,          32'h0);

    // Cold miss at 0x40, ack three cycles after the miss.
    step();
    reset = 1'b0;
    settle();
    check_eq("cold_stall_t",  {31'd0, bus.ic_stall}, 32'd1);
    check_eq("cold_instr_t",  bus.instr,             32'h0);
    check_eq("cold_req_t",    {31'd0, bus.mem_req},  32'd0);
    step();
    settle();
    check_eq("cold_req_t1",   {31'd0, bus.mem_req},  32'd1);
    check_eq("cold_addr_t1",  bus.mem_addr,          32'h40);
    check_eq("cold_stall_t1", {31'd0, bus.ic_stall}, 32'd1);
    step();
    settle();
    check_eq("cold_req_t2",   {31'd0, bus.mem_req},  32'd1);
    step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = {32'h4, 32'h3, 32'h2, 32'h1};
    settle();
    check_eq("cold_req_t3",   {31'd0, bus.mem_req},  32'd1);
    step();
    bus.mem_ack = 1'b0;
    settle();
    check_eq("cold_stall_done", {31'd0, bus.ic_stall}, 32'd0);
    check_eq("cold_instr_done", bus.instr,             32'h1);
    check_eq("cold_req_done",   {31'd0, bus.mem_req},  32'd0);

    // Hits in the freshly filled line.
    step();
    bus.addr = 32'h48;
    settle();
    check_eq("hit48_instr", bus.instr,             32'h3);
    check_eq("hit48_stall", {31'd0, bus.ic_stall}, 32'd0);
    step();
    bus.addr = 32'h4C;
    settle();
    check_eq("hit4c_instr", bus.instr,             32'h4);
    check_eq("hit4c_req",   {31'd0, bus.mem_req},  32'd0);

    // Conflict miss at 0x00 with an immediate ack: two stall cycles.
    step();
    bus.addr = 32'h00;
    settle();
    check_eq("conf_stall_t", {31'd0, bus.ic_stall}, 32'd1);
    step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = {32'h8, 32'h7, 32'h6, 32'h5};
    settle();
    check_eq("conf_addr",    bus.mem_addr,          32'h00);
    check_eq("conf_stall_f", {31'd0, bus.ic_stall}, 32'd1);
    step();
    bus.mem_ack = 1'b0;
    settle();
    check_eq("conf_stall_done", {31'd0, bus.ic_stall}, 32'd0);
    check_eq("conf_instr",      bus.instr,             32'h5);

    // 0x40 was evicted; refill it while the PC jumps to 0x10.
    step();
    bus.addr = 32'h40;
    settle();
    check_eq("evict_stall", {31'd0, bus.ic_stall}, 32'd1);
    step();
    bus.addr = 32'h10;
    settle();
    check_eq("pcchg_addr", bus.mem_addr,          32'h40);
    check_eq("pcchg_req",  {31'd0, bus.mem_req},  32'd1);
    step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = {32'h4, 32'h3, 32'h2, 32'h1};
    settle();
    check_eq("pcchg_addr_hold", bus.mem_addr, 32'h40);
    step();
    bus.mem_ack = 1'b0;
    settle();
    check_eq("pcchg_miss_stall", {31'd0, bus.ic_stall}, 32'd1);
    check_eq("pcchg_miss_req",   {31'd0, bus.mem_req},  32'd0);
    step();
    settle();
    check_eq("pcchg_addr10", bus.mem_addr,         32'h10);
    check_eq("pcchg_req10",  {31'd0, bus.mem_req}, 32'd1);
    step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = {32'h14, 32'h13, 32'h12, 32'h11};
    settle();
    step();
    bus.mem_ack = 1'b0;
    bus.addr    = 32'h14;
    settle();
    check_eq("fill10_instr", bus.instr, 32'h12);
    step();
    bus.addr = 32'h40;
    settle();
    check_eq("fill40_kept_instr", bus.instr,             32'h1);
    check_eq("fill40_kept_stall", {31'd0, bus.ic_stall}, 32'd0);

    // Reset two cycles into a fill of 0x80, with an ack on the reset edge.
    step();
    bus.addr = 32'h80;
    settle();
    check_eq("rf_stall_t", {31'd0, bus.ic_stall}, 32'd1);
    step();
    settle();
    check_eq("rf_req_t1", {31'd0, bus.mem_req}, 32'd1);
    step();
    reset         = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = {32'hDEAD0004, 32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001};
    settle();
    check_eq("rf_req_in_reset", {31'd0, bus.mem_req}, 32'd0);
    step();
    reset     = 1'b0;
    bus.rd_en = 1'b0;
    settle();
    check_eq("rf_req_after",   {31'd0, bus.mem_req},  32'd0);
    check_eq("rf_stall_after", {31'd0, bus.ic_stall}, 32'd0);
    step();
    bus.mem_ack = 1'b0;
    settle();
    check_eq("rf_late_ack_req", {31'd0, bus.mem_req}, 32'd0);
    bus.rd_en = 1'b1;
    bus.addr  = 32'h40;
    settle();
    check_eq("rf_lookup40_stall", {31'd0, bus.ic_stall}, 32'd1);
    check_eq("rf_lookup40_instr", bus.instr,             32'h0);

    // Held ack across three cycles during the refill of 0x40.
    step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = {32'h4, 32'h3, 32'h2, 32'h1};
    settle();
    check_eq("held_req_t1", {31'd0, bus.mem_req}, 32'd1);
    step();
    bus.mem_rdata = {32'hBAD4, 32'hBAD3, 32'hBAD2, 32'hBAD1};
    settle();
    check_eq("held_instr_a", bus.instr,             32'h1);
    check_eq("held_stall_a", {31'd0, bus.ic_stall}, 32'd0);
    check_eq("held_req_a",   {31'd0, bus.mem_req},  32'd0);
    step();
    settle();
    check_eq("held_instr_b", bus.instr,            32'h1);
    check_eq("held_req_b",   {31'd0, bus.mem_req}, 32'd0);
    step();
    bus.mem_ack = 1'b0;
    bus.addr    = 32'h44;
    settle();
    check_eq("held_instr_44", bus.instr,            32'h2);
    check_eq("held_req_c",    {31'd0, bus.mem_req}, 32'd0);

    // No request: no stall, NOP out.
    step();
    bus.rd_en = 1'b0;
    settle();
    check_eq("idle_instr", bus.instr,             32'h0);
    check_eq("idle_stall", {31'd0, bus.ic_stall}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net against a runaway simulation.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
